// File: rtl/mcore_pkg.sv
// mcore_pkg: shared state type and default sizing for the mining-core dispatcher.
package mcore_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_LO,
      WAIT_HI,
      EVAL,
      FIN
   } dispatch_state_t;

   localparam int unsigned NONCE_W_DEFAULT = 32;
   localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/dispatch_nonce_gen.sv
// dispatch_nonce_gen: nonce counter plus the registered random-data word sent to
// the core. The low NONCE_W bits of the held seed are offset by the counter.
module dispatch_nonce_gen
   import mcore_pkg::*;
#(
   parameter int unsigned NONCE_W = NONCE_W_DEFAULT
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               inc_i,
   input  logic               update_i,
   input  logic [255:0]       seed_i,
   output logic [NONCE_W-1:0] ctr_o,
   output logic [255:0]       rdata_o
);

   logic [NONCE_W-1:0] ctr_q, ctr_d;
   logic [255:0]       seed_q, seed_d;
   logic [255:0]       rdata_q, rdata_d;

   // Next counter/seed; the data word is formed from the next values so that it
   // is already correct in the cycle the start pulse goes out.
   always_comb begin
      ctr_d  = ctr_q;
      seed_d = seed_q;
      if (load_i) begin
         ctr_d  = '0;
         seed_d = seed_i;
      end else if (inc_i) begin
         ctr_d = ctr_q + NONCE_W'(1);
      end
      rdata_d                = seed_d;
      rdata_d[NONCE_W-1:0]   = seed_d[NONCE_W-1:0] + ctr_d;
   end

   // Counter, held seed and data word registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctr_q   <= '0;
         seed_q  <= '0;
         rdata_q <= '0;
      end else begin
         ctr_q  <= ctr_d;
         seed_q <= seed_d;
         if (update_i) begin
            rdata_q <= rdata_d;
         end
      end
   end

   assign ctr_o   = ctr_q;
   assign rdata_o = rdata_q;

endmodule

// File: rtl/mcore_dispatch.sv
// mcore_dispatch: walks a nonce range on one mining core, one attempt per core
// completion, stopping on first hit, range exhaustion or host abort.
// Optional per-attempt watchdog: define MCORE_DISPATCH_TIMEOUT_EN.
module mcore_dispatch
   import mcore_pkg::*;
#(
   parameter int unsigned NONCE_W = NONCE_W_DEFAULT,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_go,
   input  logic               i_abort,
   input  logic [255:0]       i_rdata_seed,
   input  logic [NONCE_W-1:0] i_iter_limit,
   output logic               o_start,
   output logic [255:0]       o_rdata,
   input  logic               i_rf,
   input  logic               i_found,
   input  logic [255:0]       i_sha256,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_hit,
   output logic               o_timeout,
   output logic [NONCE_W-1:0] o_hit_nonce,
   output logic [255:0]       o_hit_sha256,
   output logic [NONCE_W-1:0] o_attempts
);

   if (NONCE_W == 0 || NONCE_W > 64 || TIMEOUT == 0) begin : g_bad_param
      $error("mcore_dispatch: NONCE_W must be 1..64 and TIMEOUT at least 1");
   end

   dispatch_state_t    state_q, state_d;
   logic [NONCE_W-1:0] limit_q, attempts_q, hit_nonce_q, ctr;
   logic [255:0]       hit_sha_q;
   logic               hit_q;
   logic               go_start, capture, ctr_inc, rdata_upd, wd_fire;

`ifdef MCORE_DISPATCH_TIMEOUT_EN
   logic [31:0] wd_q;
   logic        timeout_q;
   logic        waiting;

   assign waiting = (state_q == WAIT_LO) || (state_q == WAIT_HI);
   // Fires only when nothing of higher priority (core ready, abort) happens.
   assign wd_fire = waiting && (wd_q == TIMEOUT - 1) && !i_abort &&
                    !((state_q == WAIT_HI) && i_rf);

   // Cycles spent waiting on the core during the current attempt.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wd_q <= '0;
      end else if (state_q == ISSUE) begin
         wd_q <= '0;
      end else if (waiting) begin
         wd_q <= wd_q + 32'd1;
      end
   end

   // Sticky watchdog flag for the current run.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         timeout_q <= 1'b0;
      end else if (go_start) begin
         timeout_q <= 1'b0;
      end else if (wd_fire) begin
         timeout_q <= 1'b1;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign wd_fire   = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath strobes.
   always_comb begin
      state_d  = state_q;
      go_start = 1'b0;
      capture  = 1'b0;
      ctr_inc  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_go) begin
               go_start = 1'b1;
               state_d  = (i_iter_limit == '0) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            state_d = i_abort ? FIN : WAIT_LO;
         end
         WAIT_LO: begin
            if (i_abort || wd_fire) begin
               state_d = FIN;
            end else if (!i_rf) begin
               state_d = WAIT_HI;
            end
         end
         WAIT_HI: begin
            // A completion seen together with abort is still recorded.
            if (i_rf) begin
               capture = 1'b1;
               state_d = i_abort ? FIN : EVAL;
            end else if (i_abort || wd_fire) begin
               state_d = FIN;
            end
         end
         EVAL: begin
            if (i_abort || hit_q || (attempts_q == limit_q)) begin
               state_d = FIN;
            end else begin
               ctr_inc = 1'b1;
               state_d = ISSUE;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rdata_upd = (state_d == ISSUE);
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      o_start = (state_q == ISSUE);
      o_busy  = (state_q != IDLE);
      o_done  = (state_q == FIN);
   end

   // Run parameters, attempt count and hit capture.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         limit_q     <= '0;
         attempts_q  <= '0;
         hit_q       <= 1'b0;
         hit_nonce_q <= '0;
         hit_sha_q   <= '0;
      end else begin
         if (go_start) begin
            limit_q    <= i_iter_limit;
            attempts_q <= '0;
            hit_q      <= 1'b0;
         end
         if (capture) begin
            attempts_q <= attempts_q + NONCE_W'(1);
            if (i_found) begin
               hit_q       <= 1'b1;
               hit_nonce_q <= ctr;
               hit_sha_q   <= i_sha256;
            end
         end
      end
   end

   dispatch_nonce_gen #(
      .NONCE_W (NONCE_W)
   ) u_nonce_gen (
      .clk_i    (i_clk),
      .rst_i    (i_reset),
      .load_i   (go_start),
      .inc_i    (ctr_inc),
      .update_i (rdata_upd),
      .seed_i   (i_rdata_seed),
      .ctr_o    (ctr),
      .rdata_o  (o_rdata)
   );

   assign o_hit        = hit_q;
   assign o_hit_nonce  = hit_nonce_q;
   assign o_hit_sha256 = hit_sha_q;
   assign o_attempts   = attempts_q;

endmodule

// File: tb/tb_mcore_dispatch.sv
// tb_mcore_dispatch: directed table, abort/reset/timeout sequences and random
// runs against a behavioural core model and a run-level reference model.
module tb_mcore_dispatch;

   localparam int unsigned NW = 32;
   localparam int unsigned TO = 16;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          go    = 1'b0;
   logic          abort = 1'b0;
   logic [255:0]  seed  = '0;
   logic [NW-1:0] limit = '0;
   logic          rf    = 1'b1;
   logic          found = 1'b0;
   logic [255:0]  sha   = '0;
   logic          start, busy, done, hit, tmo;
   logic [255:0]  rdata, hit_sha;
   logic [NW-1:0] hit_nonce, attempts;

   mcore_dispatch #(
      .NONCE_W (NW),
      .TIMEOUT (TO)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_go         (go),
      .i_abort      (abort),
      .i_rdata_seed (seed),
      .i_iter_limit (limit),
      .o_start      (start),
      .o_rdata      (rdata),
      .i_rf         (rf),
      .i_found      (found),
      .i_sha256     (sha),
      .o_busy       (busy),
      .o_done       (done),
      .o_hit        (hit),
      .o_timeout    (tmo),
      .o_hit_nonce  (hit_nonce),
      .o_hit_sha256 (hit_sha),
      .o_attempts   (attempts)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   // Core model: ready idles high, drops on start, returns after c_lat cycles.
   int           c_lat   = 2;
   int           c_cnt   = 0;
   int           c_idx   = 0;
   int           c_fa    = 0;
   bit           c_never = 1'b0;
   logic [255:0] c_hash  = '0;
   always @(negedge clk) begin
      if (rst) begin
         rf    = 1'b1;
         found = 1'b0;
         c_cnt = 0;
      end else if (start) begin
         rf    = 1'b0;
         found = 1'($urandom);
         sha   = rand256();
         c_cnt = c_lat;
         c_idx++;
      end else if (c_cnt > 0) begin
         c_cnt--;
         if (c_cnt == 0 && !c_never) begin
            rf    = 1'b1;
            found = (c_idx == c_fa);
            sha   = found ? c_hash : rand256();
         end
      end
   end

   // Monitor: start pulses with their data word, done pulses.
   logic [255:0] st_data[$];
   int unsigned  st_cyc[$];
   int unsigned  done_cnt = 0;
   int unsigned  done_cyc = 0;
   always @(negedge clk) begin
      if (start) begin
         st_data.push_back(rdata);
         st_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // Run-level reference: attempts stop at the first hit or at the limit.
   function automatic void ref_run(input logic [NW-1:0] lim, input int fa,
                                   output int n, output logic h);
      h = (fa != 0) && (fa <= int'(lim));
      n = (lim == 0) ? 0 : (h ? fa : int'(lim));
   endfunction

   task automatic chk_zero(input string p);
      chk({p, "_start"}, start, 0);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_done"}, done, 0);
      chk({p, "_hit"}, hit, 0);
      chk({p, "_timeout"}, tmo, 0);
      chk({p, "_nonce"}, hit_nonce, 0);
      chk({p, "_sha"}, hit_sha, 0);
      chk({p, "_attempts"}, attempts, 0);
      chk({p, "_rdata"}, rdata, 0);
   endtask

   task automatic launch(input logic [255:0] s, input logic [NW-1:0] l, output int unsigned gc);
      @(negedge clk);
      st_data.delete();
      st_cyc.delete();
      done_cnt = 0;
      c_idx    = 0;
      seed     = s;
      limit    = l;
      go       = 1'b1;
      gc       = cyc;
      @(negedge clk);
      go    = 1'b0;
      seed  = ~s;
      limit = l + 7;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("run_ended", done_cnt != 0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_start(output int unsigned s);
      int k = 0;
      while (st_data.size() == 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("start_seen", st_data.size() != 0, 1);
      s = (st_data.size() != 0) ? st_cyc[0] : cyc;
   endtask

   task automatic run_case(input logic [255:0] s, input logic [NW-1:0] l, input int fa,
                           input int lat, input logic [255:0] hh,
                           output int o_st, output int o_att, output logic o_h,
                           output logic [NW-1:0] o_nc);
      int unsigned  gc;
      int           n, m;
      logic         he;
      logic [255:0] exp_rd;
      c_fa   = fa;
      c_lat  = lat;
      c_hash = hh;
      launch(s, l, gc);
      wait_done(200);
      ref_run(l, fa, n, he);
      chk("done_count", done_cnt, 1);
      chk("start_count", st_data.size(), n);
      m = (st_data.size() < n) ? st_data.size() : n;
      for (int k = 0; k < m; k++) begin
         exp_rd       = s;
         exp_rd[31:0] = s[31:0] + 32'(k);
         chk($sformatf("rdata%0d", k), st_data[k], exp_rd);
         if (k == 0) chk("first_start_cycle", st_cyc[0], gc + 1);
         else chk($sformatf("gap%0d", k), st_cyc[k] - st_cyc[k-1], lat + 2);
      end
      if (n == 0) chk("done_cycle_nolimit", done_cyc, gc + 1);
      else if (m == n) chk("done_after_last", done_cyc - st_cyc[m-1], lat + 2);
      chk("attempts", attempts, n);
      chk("hit", hit, he);
      if (he) begin
         chk("hit_nonce", hit_nonce, fa - 1);
         chk("hit_sha", hit_sha, hh);
      end
      chk("timeout_clear", tmo, 0);
      chk("busy_after", busy, 0);
      chk("done_single", done, 0);
      o_st  = st_data.size();
      o_att = int'(attempts);
      o_h   = hit;
      o_nc  = hit_nonce;
   endtask

   typedef struct {
      logic [223:0] seed_hi;
      logic [31:0]  seed_lo;
      logic [31:0]  lim;
      int           fa;
      int           lat;
      logic [255:0] hh;
      int           e_starts;
      int           e_att;
      logic         e_hit;
      logic [31:0]  e_nonce;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      int unsigned  s0, gc;
      int           st, at;
      logic         h;
      logic [NW-1:0] nc;
      logic [223:0] pat;
      logic [255:0] hv;

      pat = {7{32'hC3A5_0F1E}};
      tbl[0] = '{224'h0, 32'h0000_0000, 3, 0, 5, 256'h0, 3, 3, 1'b0, 0};
      tbl[1] = '{pat, 32'hFFFF_FFFE, 4, 0, 3, 256'h0, 4, 4, 1'b0, 0};
      tbl[2] = '{pat, 32'h0000_0100, 5, 2, 4, 256'h1, 2, 2, 1'b1, 1};
      tbl[3] = '{pat, 32'h0000_0007, 0, 0, 2, 256'h0, 0, 0, 1'b0, 0};
      tbl[4] = '{pat, 32'h1234_5678, 1, 1, 2, {8{32'h5A5A_1234}}, 1, 1, 1'b1, 0};
      tbl[5] = '{pat, 32'h8000_0000, 3, 3, 6, {8{32'h0BAD_F00D}}, 3, 3, 1'b1, 2};
      tbl[6] = '{pat, 32'h0000_00FF, 3, 5, 2, 256'h2, 3, 3, 1'b0, 0};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_case({tbl[i].seed_hi, tbl[i].seed_lo}, tbl[i].lim, tbl[i].fa, tbl[i].lat,
                  tbl[i].hh, st, at, h, nc);
         chk($sformatf("tbl%0d_starts", i), st, tbl[i].e_starts);
         chk($sformatf("tbl%0d_attempts", i), at, tbl[i].e_att);
         chk($sformatf("tbl%0d_hit", i), h, tbl[i].e_hit);
         if (tbl[i].e_hit) chk($sformatf("tbl%0d_nonce", i), nc, tbl[i].e_nonce);
      end

      // Abort two cycles into WAIT_HI; a go pulse while busy must be ignored.
      c_fa  = 0;
      c_lat = 10;
      launch(rand256(), 5, gc);
      wait_start(s0);
      while (cyc < s0 + 2) @(negedge clk);
      go    = 1'b1;
      limit = 9;
      @(negedge clk);
      go = 1'b0;
      while (cyc < s0 + 4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(50);
      chk("abort_done_cycle", done_cyc, s0 + 5);
      chk("abort_done_count", done_cnt, 1);
      chk("abort_starts", st_data.size(), 1);
      chk("abort_attempts", attempts, 0);
      chk("abort_hit", hit, 0);
      chk("abort_busy", busy, 0);
      repeat (12) @(negedge clk);

      // Abort arriving with the hit: the hit is still recorded.
      hv     = rand256();
      c_fa   = 1;
      c_lat  = 4;
      c_hash = hv;
      launch(rand256(), 5, gc);
      wait_start(s0);
      while (cyc < s0 + 4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(50);
      chk("abhit_done_cycle", done_cyc, s0 + 5);
      chk("abhit_starts", st_data.size(), 1);
      chk("abhit_hit", hit, 1);
      chk("abhit_nonce", hit_nonce, 0);
      chk("abhit_sha", hit_sha, hv);
      chk("abhit_attempts", attempts, 1);
      repeat (4) @(negedge clk);

`ifdef MCORE_DISPATCH_TIMEOUT_EN
      // Core never reports ready: watchdog ends the run.
      c_fa    = 0;
      c_lat   = 4;
      c_never = 1'b1;
      launch(rand256(), 3, gc);
      wait_start(s0);
      wait_done(100);
      chk("wd_done_cycle", done_cyc - s0, 17);
      chk("wd_timeout", tmo, 1);
      chk("wd_starts", st_data.size(), 1);
      chk("wd_attempts", attempts, 0);
      c_never = 1'b0;
      repeat (4) @(negedge clk);
`endif

      for (int r = 0; r < 20; r++) begin
         run_case(rand256(), NW'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
                  int'($urandom_range(2, 6)), rand256(), st, at, h, nc);
      end

      // Asynchronous reset in the middle of a run.
      c_fa  = 0;
      c_lat = 6;
      launch(rand256() | 256'h1, 3, gc);
      wait_start(s0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_done", done_cnt, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_starts", st_data.size(), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
